// File: rtl/dccm_arb_if.sv
// DCCM arbiter bus bundle: LSU requester, DMA requester and DCCM memory-port signals.
// slave = arbiter view, master = environment (LSU/DMA/memory) view.
interface dccm_arb_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] lsu_raddr;
    logic            lsu_rvalid_in;
    logic [XLEN-1:0] lsu_rdata;
    logic            lsu_rvalid_out;
    logic [XLEN-1:0] lsu_waddr;
    logic [XLEN-1:0] lsu_wdata;
    logic            lsu_wen;
    logic            lsu_stall;

    logic            dma_req;
    logic            dma_we;
    logic [XLEN-1:0] dma_addr;
    logic [XLEN-1:0] dma_wdata;
    logic            dma_gnt;
    logic [XLEN-1:0] dma_rdata;
    logic            dma_rvalid;

    logic [XLEN-1:0] mem_raddr;
    logic            mem_rvalid_in;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid_out;
    logic [XLEN-1:0] mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_wen;

    modport slave (
        input  lsu_raddr, lsu_rvalid_in, lsu_waddr, lsu_wdata, lsu_wen,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, mem_rvalid_out,
        output lsu_rdata, lsu_rvalid_out, lsu_stall,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_raddr, mem_rvalid_in, mem_waddr, mem_wdata, mem_wen
    );

    modport master (
        output lsu_raddr, lsu_rvalid_in, lsu_waddr, lsu_wdata, lsu_wen,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, mem_rvalid_out,
        input  lsu_rdata, lsu_rvalid_out, lsu_stall,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_raddr, mem_rvalid_in, mem_waddr, mem_wdata, mem_wen
    );
endinterface

// File: rtl/dccm_arb.sv
// LSU/DMA arbiter for the DCCM read and write ports; LSU wins conflicts.
// Define DCCM_ARB_STARVE_EN to force a DMA grant after STARVE_LIMIT consecutive denials.
module dccm_arb #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    dccm_arb_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("dccm_arb: STARVE_LIMIT must be in 1..15");
    end

    logic            conflict;
    logic            force_dma;
    logic            gnt;
    logic            owner_q, owner_d;
    logic            ovalid_q, ovalid_d;
    logic            ret_lsu, ret_dma;
    logic [XLEN-1:0] lsu_rdata_q, lsu_rdata_d;
    logic [XLEN-1:0] dma_rdata_q, dma_rdata_d;

    // A DMA request only competes with the LSU on the port it targets.
    assign conflict = bus.dma_req & (bus.dma_we ? bus.lsu_wen : bus.lsu_rvalid_in);

`ifdef DCCM_ARB_STARVE_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!bus.dma_req || gnt) begin
            starve_d = '0;
        end else if (conflict && starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_dma = conflict & (starve_q == LIMIT);
`else
    assign force_dma = 1'b0;
`endif

    assign gnt           = bus.dma_req & (~conflict | force_dma);
    assign bus.dma_gnt   = gnt;
    assign bus.lsu_stall = force_dma;

    always_comb begin
        bus.mem_rvalid_in = 1'b0;
        bus.mem_raddr     = '0;
        owner_d           = 1'b0;
        if (gnt && !bus.dma_we) begin
            bus.mem_rvalid_in = 1'b1;
            bus.mem_raddr     = bus.dma_addr;
            owner_d           = 1'b1;
        end else if (bus.lsu_rvalid_in) begin
            bus.mem_rvalid_in = 1'b1;
            bus.mem_raddr     = bus.lsu_raddr;
        end
        ovalid_d = bus.mem_rvalid_in;
    end

    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        if (gnt && bus.dma_we) begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end else if (bus.lsu_wen) begin
            bus.mem_wen   = 1'b1;
            bus.mem_waddr = bus.lsu_waddr;
            bus.mem_wdata = bus.lsu_wdata;
        end
    end

    // Returns with no recorded read (e.g. straight after reset) are dropped.
    assign ret_lsu = bus.mem_rvalid_out & ovalid_q & ~owner_q;
    assign ret_dma = bus.mem_rvalid_out & ovalid_q &  owner_q;

    always_comb begin
        lsu_rdata_d = ret_lsu ? bus.mem_rdata : lsu_rdata_q;
        dma_rdata_d = ret_dma ? bus.mem_rdata : dma_rdata_q;
    end

    assign bus.lsu_rvalid_out = ret_lsu;
    assign bus.dma_rvalid     = ret_dma;
    assign bus.lsu_rdata      = lsu_rdata_d;
    assign bus.dma_rdata      = dma_rdata_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= 1'b0;
            ovalid_q    <= 1'b0;
            lsu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            ovalid_q    <= ovalid_d;
            lsu_rdata_q <= lsu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_dccm_arb.sv
// Self-checking bench for dccm_arb: directed scenarios plus a read-return scoreboard.
// Expectations follow DCCM_ARB_STARVE_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dccm_arb;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned LIMIT = 4;
`ifdef DCCM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    typedef struct packed {
        logic        is_dma;
        logic [31:0] data;
    } ret_t;

    logic  clk    = 1'b0;
    logic  rst_n  = 1'b0;
    logic  inject = 1'b0;
    int    checks   = 0;
    int    failures = 0;
    ret_t  exp_q[$];
    ret_t  mon_e;
    logic [31:0] mon_data;

    dccm_arb_if #(.XLEN(XLEN)) bus ();

    dccm_arb #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // DCCM model: returns exactly one cycle after the request; inject forces a stray return.
    always @(posedge clk) begin
        bus.mem_rvalid_out <= bus.mem_rvalid_in | inject;
        bus.mem_rdata      <= memf(bus.mem_raddr);
    end

    always @(negedge clk) begin
        if (bus.lsu_rvalid_out || bus.dma_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ret_unexpected: lsu_rvalid=%b dma_rvalid=%b, required no return",
                         bus.lsu_rvalid_out, bus.dma_rvalid);
            end else begin
                mon_e    = exp_q.pop_front();
                mon_data = mon_e.is_dma ? bus.dma_rdata : bus.lsu_rdata;
                if (bus.dma_rvalid !== mon_e.is_dma || bus.lsu_rvalid_out !== !mon_e.is_dma
                    || mon_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL ret_route: dma_rvalid=%b lsu_rvalid=%b data=%h, required dma=%b data=%h",
                             bus.dma_rvalid, bus.lsu_rvalid_out, mon_data, mon_e.is_dma, mon_e.data);
                end
            end
        end
    end

    task automatic idle();
        bus.lsu_raddr     = '0;
        bus.lsu_rvalid_in = 1'b0;
        bus.lsu_waddr     = '0;
        bus.lsu_wdata     = '0;
        bus.lsu_wen       = 1'b0;
        bus.dma_req       = 1'b0;
        bus.dma_we        = 1'b0;
        bus.dma_addr      = '0;
        bus.dma_wdata     = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_rvalid_in, bus.mem_wen, bus.dma_gnt, bus.lsu_stall, bus.lsu_rvalid_out,
             bus.dma_rvalid, bus.lsu_rdata, bus.dma_rdata, bus.mem_raddr, bus.mem_waddr,
             bus.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b stall=%b rvin=%b wen=%b, required all outputs 0",
                     bus.dma_gnt, bus.lsu_stall, bus.mem_rvalid_in, bus.mem_wen);
        end
        inject = 1'b1;
        next_cycle();
        inject = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.lsu_rvalid_out !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.lsu_rdata !== '0) begin
            failures++;
            $display("FAIL reset_first_ret: lsu_rvalid=%b dma_rvalid=%b lsu_rdata=%h, required 0 0 0",
                     bus.lsu_rvalid_out, bus.dma_rvalid, bus.lsu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_dma_write();
        idle();
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h100;
        bus.dma_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({bus.dma_gnt, bus.mem_wen, bus.lsu_stall, bus.mem_rvalid_in} !== 4'b1100) begin
            failures++;
            $display("FAIL dma_write_ctl: gnt=%b wen=%b stall=%b rvin=%b, required 1 1 0 0",
                     bus.dma_gnt, bus.mem_wen, bus.lsu_stall, bus.mem_rvalid_in);
        end
        checks++;
        if (bus.mem_waddr !== 32'h100 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL dma_write_bus: waddr=%h wdata=%h, required 00000100 deadbeef",
                     bus.mem_waddr, bus.mem_wdata);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if ({bus.dma_gnt, bus.mem_wen, bus.mem_waddr, bus.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL idle_port: gnt=%b wen=%b waddr=%h wdata=%h, required all 0",
                     bus.dma_gnt, bus.mem_wen, bus.mem_waddr, bus.mem_wdata);
        end
        next_cycle();
    endtask

    task automatic test_split_ports();
        idle();
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h40;
        bus.dma_req       = 1'b1;
        bus.dma_we        = 1'b1;
        bus.dma_addr      = 32'h80;
        bus.dma_wdata     = 32'h1234_5678;
        exp_q.push_back('{is_dma: 1'b0, data: memf(32'h40)});
        @(negedge clk);
        checks++;
        if ({bus.dma_gnt, bus.lsu_stall, bus.mem_rvalid_in, bus.mem_wen} !== 4'b1011) begin
            failures++;
            $display("FAIL split_ctl: gnt=%b stall=%b rvin=%b wen=%b, required 1 0 1 1",
                     bus.dma_gnt, bus.lsu_stall, bus.mem_rvalid_in, bus.mem_wen);
        end
        checks++;
        if (bus.mem_raddr !== 32'h40 || bus.mem_waddr !== 32'h80 || bus.mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL split_bus: raddr=%h waddr=%h wdata=%h, required 00000040 00000080 12345678",
                     bus.mem_raddr, bus.mem_waddr, bus.mem_wdata);
        end
        next_cycle();
        idle();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_write_conflict();
        idle();
        bus.lsu_wen   = 1'b1;
        bus.lsu_waddr = 32'h300;
        bus.lsu_wdata = 32'hCAFE_0001;
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 32'h304;
        bus.dma_wdata = 32'h0BAD_0002;
        @(negedge clk);
        checks++;
        if (bus.dma_gnt !== 1'b0 || bus.lsu_stall !== 1'b0 || bus.mem_waddr !== 32'h300
            || bus.mem_wdata !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL wr_conflict: gnt=%b stall=%b waddr=%h wdata=%h, required 0 0 00000300 cafe0001",
                     bus.dma_gnt, bus.lsu_stall, bus.mem_waddr, bus.mem_wdata);
        end
        next_cycle();
        idle();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_starve();
        int unsigned n;
        logic        exp_gnt;
        logic [31:0] la;
        n = STARVE_ON ? LIMIT + 1 : 20;
        idle();
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h200;
        for (int unsigned i = 0; i < n; i++) begin
            exp_gnt = STARVE_ON && (i == LIMIT);
            la      = 32'h1000 + 32'(4 * i);
            bus.lsu_rvalid_in = 1'b1;
            bus.lsu_raddr     = la;
            if (exp_gnt) exp_q.push_back('{is_dma: 1'b1, data: memf(32'h200)});
            else         exp_q.push_back('{is_dma: 1'b0, data: memf(la)});
            @(negedge clk);
            checks++;
            if (bus.dma_gnt !== exp_gnt || bus.lsu_stall !== exp_gnt) begin
                failures++;
                $display("FAIL starve_gnt[%0d]: gnt=%b stall=%b, required %b %b",
                         i, bus.dma_gnt, bus.lsu_stall, exp_gnt, exp_gnt);
            end
            checks++;
            if (bus.mem_raddr !== (exp_gnt ? 32'h200 : la)) begin
                failures++;
                $display("FAIL starve_raddr[%0d]: raddr=%h, required %h",
                         i, bus.mem_raddr, exp_gnt ? 32'h200 : la);
            end
            next_cycle();
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.dma_rvalid !== STARVE_ON) begin
            failures++;
            $display("FAIL starve_ret: dma_rvalid=%b, required %b", bus.dma_rvalid, STARVE_ON);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h10;
        exp_q.push_back('{is_dma: 1'b0, data: memf(32'h10)});
        next_cycle();
        idle();
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h20;
        exp_q.push_back('{is_dma: 1'b1, data: memf(32'h20)});
        @(negedge clk);
        checks++;
        if (bus.lsu_rvalid_out !== 1'b1 || bus.dma_rvalid !== 1'b0 || bus.lsu_rdata !== memf(32'h10)
            || bus.dma_gnt !== 1'b1) begin
            failures++;
            $display("FAIL b2b_cycle1: lsu_rvalid=%b dma_rvalid=%b gnt=%b lsu_rdata=%h, required 1 0 1 %h",
                     bus.lsu_rvalid_out, bus.dma_rvalid, bus.dma_gnt, bus.lsu_rdata, memf(32'h10));
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (bus.dma_rvalid !== 1'b1 || bus.lsu_rvalid_out !== 1'b0 || bus.dma_rdata !== memf(32'h20)
            || bus.lsu_rdata !== memf(32'h10)) begin
            failures++;
            $display("FAIL b2b_cycle2: dma_rvalid=%b lsu_rvalid=%b dma_rdata=%h lsu_rdata=%h, required 1 0 %h %h",
                     bus.dma_rvalid, bus.lsu_rvalid_out, bus.dma_rdata, bus.lsu_rdata,
                     memf(32'h20), memf(32'h10));
        end
        next_cycle();
    endtask

    task automatic test_reset_drop();
        idle();
        bus.dma_req  = 1'b1;
        bus.dma_addr = 32'h400;
        @(negedge clk);
        checks++;
        if (bus.dma_gnt !== 1'b1 || bus.mem_rvalid_in !== 1'b1 || bus.mem_raddr !== 32'h400) begin
            failures++;
            $display("FAIL rst_drop_grant: gnt=%b rvin=%b raddr=%h, required 1 1 00000400",
                     bus.dma_gnt, bus.mem_rvalid_in, bus.mem_raddr);
        end
        next_cycle();
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (bus.dma_rvalid !== 1'b0 || bus.lsu_rvalid_out !== 1'b0 || bus.dma_rdata !== '0) begin
            failures++;
            $display("FAIL rst_drop_ret: dma_rvalid=%b lsu_rvalid=%b dma_rdata=%h, required 0 0 0",
                     bus.dma_rvalid, bus.lsu_rvalid_out, bus.dma_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        bus.lsu_rvalid_in = 1'b1;
        bus.lsu_raddr     = 32'h500;
        bus.dma_req       = 1'b1;
        bus.dma_addr      = 32'h504;
        exp_q.push_back('{is_dma: 1'b0, data: memf(32'h500)});
        @(negedge clk);
        checks++;
        if (bus.dma_gnt !== 1'b0 || bus.lsu_stall !== 1'b0 || bus.mem_raddr !== 32'h500) begin
            failures++;
            $display("FAIL rst_drop_starve: gnt=%b stall=%b raddr=%h, required 0 0 00000500",
                     bus.dma_gnt, bus.lsu_stall, bus.mem_raddr);
        end
        next_cycle();
        idle();
        @(negedge clk);
        next_cycle();
    endtask

    initial begin
        idle();
        test_reset();
        test_dma_write();
        test_split_ports();
        test_write_conflict();
        test_starve();
        test_back_to_back();
        test_reset_drop();
        repeat (2) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ret_missing: %0d returns outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
